// File: rtl/packager_arbiter.sv
// Round-robin front end for a FifoPackager: locks one producer for a full
// group of p_num_concat beats and forwards its beats combinationally.
module packager_arbiter_lane #(
  parameter int p_bit_width = 3,
  parameter int IW          = 2,
  parameter int ID          = 0
) (
  input  logic [p_bit_width-1:0] msg,
  input  logic [IW-1:0]          sel,
  input  logic                   grant,
  input  logic                   out_rdy,
  output logic [p_bit_width-1:0] beat,
  output logic                   rdy
);
  assign beat = msg;
  assign rdy  = grant && (sel == IW'(ID)) && out_rdy;
endmodule

module packager_arbiter #(
  parameter int p_bit_width  = 3,
  parameter int p_num_concat = 2,
  parameter int p_num_req    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_num_req*p_bit_width-1:0]   req_msg,
  input  logic [p_num_req-1:0]               req_val,
  output logic [p_num_req-1:0]               req_rdy,
  output logic [p_bit_width-1:0]             out_msg,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [$clog2(p_num_req)-1:0]       out_id,
  output logic                               out_last
);
  localparam int IW = $clog2(p_num_req);
  localparam int CW = $clog2(p_num_concat) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt, ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [IW-1:0]   win, sel;
  logic            found, vld, last_raw, hs, grant;
  logic [p_bit_width-1:0] beat [p_num_req];
  logic [p_num_req-1:0]   lane_rdy;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IW'(p_num_req-1)) ? '0 : v + 1'b1;
  endfunction

  // Scan downward so the index closest to ptr (modulo p_num_req) wins last.
  always_comb begin
    logic [IW-1:0] idx;
    int            sum;
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    sum   = 0;
    for (int k = p_num_req-1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= p_num_req) sum = sum - p_num_req;
      idx = IW'(sum);
      if (req_val[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel      = (state == BURST) ? owner : win;
    vld      = (state == BURST) ? req_val[owner] : found;
    last_raw = (state == BURST) ? (cnt == CW'(p_num_concat-1))
                                : ((p_num_concat == 1) && found);
    hs       = vld && out_rdy;
  end

  // Outputs are forced quiet while reset is held; state logic needs no gating
  // because the registers are pinned by the async clear.
  assign grant    = reset && vld;
  assign out_val  = grant;
  assign out_id   = reset ? sel : '0;
  assign out_msg  = reset ? beat[sel] : '0;
  assign out_last = reset && last_raw;
  assign req_rdy  = lane_rdy;

  for (genvar i = 0; i < p_num_req; i++) begin : g_lane
    packager_arbiter_lane #(
      .p_bit_width (p_bit_width),
      .IW          (IW),
      .ID          (i)
    ) u_lane (
      .msg     (req_msg[i*p_bit_width +: p_bit_width]),
      .sel     (sel),
      .grant   (grant),
      .out_rdy (out_rdy),
      .beat    (beat[i]),
      .rdy     (lane_rdy[i])
    );
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (hs) begin
        if (p_num_concat == 1) begin
          ptr_nxt = inc_wrap(win);
        end else begin
          owner_nxt = win;
          cnt_nxt   = CW'(1);
          state_nxt = BURST;
        end
      end
      BURST: if (hs) begin
        if (last_raw) begin
          cnt_nxt   = '0;
          ptr_nxt   = inc_wrap(owner);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_packager_arbiter.sv
// Directed vector bench for packager_arbiter at default parameters.
module tb_packager_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] req_msg;
  logic [3:0]  req_val;
  logic [3:0]  req_rdy;
  logic [2:0]  out_msg;
  logic        out_val;
  logic        out_rdy;
  logic [1:0]  out_id;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  packager_arbiter #(.p_bit_width(3), .p_num_concat(2), .p_num_req(4)) dut (
    .clk(clk), .reset(reset), .req_msg(req_msg), .req_val(req_val),
    .req_rdy(req_rdy), .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
    .out_id(out_id), .out_last(out_last)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  val;
    logic [11:0] msg;
    logic        ordy;
    logic        e_val;
    logic [3:0]  e_rdy;
    logic [2:0]  e_msg;
    logic [1:0]  e_id;
    logic        e_last;
  } vec_t;

  vec_t tv[$];

  function automatic logic [11:0] pk(input logic [2:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic void add(input logic rst, input logic [3:0] val, input logic [11:0] msg,
                              input logic ordy, input logic e_val, input logic [3:0] e_rdy,
                              input logic [2:0] e_msg, input logic [1:0] e_id, input logic e_last);
    vec_t v;
    v.rst = rst; v.val = val; v.msg = msg; v.ordy = ordy;
    v.e_val = e_val; v.e_rdy = e_rdy; v.e_msg = e_msg; v.e_id = e_id; v.e_last = e_last;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, got, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic e_val, input logic [3:0] e_rdy,
                         input logic [2:0] e_msg, input logic [1:0] e_id, input logic e_last);
    chk("out_val", step, 32'(out_val), 32'(e_val));
    chk("req_rdy", step, 32'(req_rdy), 32'(e_rdy));
    chk("out_msg", step, 32'(out_msg), 32'(e_msg));
    chk("out_id", step, 32'(out_id), 32'(e_id));
    chk("out_last", step, 32'(out_last), 32'(e_last));
  endtask

  initial begin
    logic [11:0] m, l5, l6;
    m  = pk(3'd4, 3'd3, 3'd2, 3'd1);
    l5 = pk(3'd4, 3'd3, 3'd5, 3'd1);
    l6 = pk(3'd4, 3'd3, 3'd6, 3'd1);
    reset = 1'b0; req_val = 4'hf; req_msg = m; out_rdy = 1'b1;

    // reset held with everyone valid
    add(0, 4'b1111, m, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, m, 1, 0, 4'b0000, 0, 0, 0);
    // fairness: ids 0,0,1,1,2,2,3,3,0,0
    add(1, 4'b1111, m, 1, 1, 4'b0001, 1, 0, 0);
    add(1, 4'b1111, m, 1, 1, 4'b0001, 1, 0, 1);
    add(1, 4'b1111, m, 1, 1, 4'b0010, 2, 1, 0);
    add(1, 4'b1111, m, 1, 1, 4'b0010, 2, 1, 1);
    add(1, 4'b1111, m, 1, 1, 4'b0100, 3, 2, 0);
    add(1, 4'b1111, m, 1, 1, 4'b0100, 3, 2, 1);
    add(1, 4'b1111, m, 1, 1, 4'b1000, 4, 3, 0);
    add(1, 4'b1111, m, 1, 1, 4'b1000, 4, 3, 1);
    add(1, 4'b1111, m, 1, 1, 4'b0001, 1, 0, 0);
    add(1, 4'b1111, m, 1, 1, 4'b0001, 1, 0, 1);
    // lock: producer 1 beat 5, gap of 3 with producer 2 valid, then beat 6
    add(1, 4'b0110, l5, 1, 1, 4'b0010, 5, 1, 0);
    add(1, 4'b0100, l5, 1, 0, 4'b0000, 5, 1, 1);
    add(1, 4'b0100, l5, 1, 0, 4'b0000, 5, 1, 1);
    add(1, 4'b0100, l5, 1, 0, 4'b0000, 5, 1, 1);
    add(1, 4'b0110, l6, 1, 1, 4'b0010, 6, 1, 1);
    add(1, 4'b0110, l6, 1, 1, 4'b0100, 3, 2, 0);
    // backpressure mid-burst
    add(1, 4'b0110, l6, 0, 1, 4'b0000, 3, 2, 1);
    add(1, 4'b0110, l6, 0, 1, 4'b0000, 3, 2, 1);
    add(1, 4'b0110, l6, 1, 1, 4'b0100, 3, 2, 1);
    // bring ptr back to 0 via producer 3
    add(1, 4'b1000, m, 1, 1, 4'b1000, 4, 3, 0);
    add(1, 4'b1000, m, 1, 1, 4'b1000, 4, 3, 1);
    // pre-lock reselection
    add(1, 4'b1000, m, 0, 1, 4'b0000, 4, 3, 0);
    add(1, 4'b1001, m, 0, 1, 4'b0000, 1, 0, 0);
    add(1, 4'b1001, m, 1, 1, 4'b0001, 1, 0, 0);
    // mid-burst reset discards the partial group
    add(0, 4'b1001, m, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1001, m, 1, 1, 4'b0001, 1, 0, 0);
    add(1, 4'b1001, m, 1, 1, 4'b0001, 1, 0, 1);
    add(1, 4'b1001, m, 1, 1, 4'b1000, 4, 3, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      reset = tv[i].rst; req_val = tv[i].val; req_msg = tv[i].msg; out_rdy = tv[i].ordy;
      #1;
      chk_all(i, tv[i].e_val, tv[i].e_rdy, tv[i].e_msg, tv[i].e_id, tv[i].e_last);
    end

    // long owner stall: producer 3 holds the lock while others stay valid
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_val = 4'b0111; req_msg = m; out_rdy = 1'b1;
      #1;
      chk_all(100 + k, 0, 4'b0000, 4, 3, 1);
    end
    @(negedge clk);
    req_val = 4'b1000; req_msg = pk(3'd7, 3'd3, 3'd2, 3'd1);
    #1;
    chk_all(110, 1, 4'b1000, 7, 3, 1);

    // next grant wraps to 0, then reset asserted between clock edges
    @(negedge clk);
    req_val = 4'b1111; req_msg = m;
    #1;
    chk_all(111, 1, 4'b0001, 1, 0, 0);
    @(negedge clk);
    #1;
    chk_all(112, 1, 4'b0001, 1, 0, 1);
    #1;
    reset = 1'b0;
    #1;
    chk_all(113, 0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all(114, 1, 4'b0001, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
